lb_cnt_ctrl: RTL and testbench
==============================

Name: lb_cnt_ctrl

Overview:
- Control stage directly upstream of a chain of NSLICE cascaded 4-bit loadable up/down counter slices.
- Drives the chain's enable (SP), load select (SD), direction (CON), carry-in (CI) and parallel load data.
- Consumes the top slice's carry-out (CO) and the assembled count Q to detect terminal count.
- Supports one-shot, periodic-reload and free-run operation, with a post-load readback check.

Parameters:
- NSLICE, 2, number of cascaded 4-bit slices. Derived count width W = 4*NSLICE.

Ports:
- CK in 1: clock, rising edge.
- CD in 1: reset, asynchronous, active-high.
- START in 1: start request, sampled in IDLE only.
- STOP in 1: abort request.
- MODE in 2: 00 one-shot, 01 periodic reload, 10 free-run, 11 treated as 00.
- DIR in 1: 1 = up, 0 = down.
- RELOAD in W: start/reload value.
- CNT_CO in 1: carry/borrow out of the top slice.
- CNT_Q in W: current counter outputs.
- CNT_SP out 1: chain clock enable.
- CNT_SD out 1: 1 = load CNT_D, 0 = count.
- CNT_CON out 1: direction to the chain.
- CNT_CI out 1: carry-in to the bottom slice.
- CNT_D out W: parallel load data.
- TC_PULSE out 1: one-cycle terminal-count strobe.
- BUSY out 1: high in any state other than IDLE.
- TC_COUNT out 8: terminal events, saturating.
- ERR out 1: sticky readback mismatch.

Behaviour:
- Counter slice convention:
  - Up: CON=1, CI=1 counts.
  - Down: CON=0, CI=0 counts.
  - Terminal condition tc = RUN & (CNT_CO == dir_r): up at all-ones, down at zero. The next enabled count edge wraps.
- CD asserted: state IDLE; all outputs 0; shadow registers (mode_r, dir_r, reload_r) 0; ERR 0; TC_COUNT 0. Takes effect immediately, without waiting for a clock edge.
- IDLE:
  - CNT_SP=0, CNT_SD=0.
  - START & ~STOP: capture MODE/DIR/RELOAD into shadow registers, clear TC_COUNT, go to LOAD.
  - START & STOP together: stay in IDLE.
- LOAD (1 cycle): CNT_SP=1, CNT_SD=1, CNT_D=reload_r. Go to VERIFY.
- VERIFY (1 cycle):
  - CNT_SP=0.
  - CNT_Q != reload_r: set ERR, go to IDLE.
  - Otherwise go to RUN.
- RUN: CNT_CON=dir_r, CNT_CI=dir_r, CNT_SD=0, CNT_SP=1, except as follows.
  - STOP: CNT_SP=0 this cycle, go to IDLE, no TC_PULSE. STOP has priority over tc.
  - tc, one-shot: CNT_SP=0, so the counter holds the terminal value. Go to IDLE.
  - tc, periodic: CNT_SD=1, CNT_D=reload_r, so the counter reloads instead of wrapping. Stay in RUN.
  - tc, free-run: natural wrap. Stay in RUN.
- tc handling: in every tc case without STOP, TC_PULSE=1 in the following cycle (registered) and TC_COUNT increments, saturating at 255.
- CNT_CON/CNT_CI hold dir_r in all states except reset. CNT_D=reload_r at all times.
- Timing and latency:
  - START sampled at edge 0 → LOAD in cycle 1 → VERIFY in cycle 2 → first count edge at the end of cycle 3.
  - TC_PULSE follows the tc cycle by exactly 1.
- START outside IDLE: ignored; shadow registers unchanged.
- RELOAD equal to the terminal value:
  - One-shot: tc in the first RUN cycle.
  - Periodic: tc every RUN cycle, TC_PULSE continuous.
- ERR: cleared only by CD; START after an error still runs normally.
- All state and output registers are clocked by CK. CNT_SP/CNT_SD are decoded combinationally from state and tc.

Test Plan (NSLICE=2, W=8):
- One-shot up, RELOAD=0xFA, START@0 → CNT_Q=0xFA after cycle 1, then FB..FF; tc while Q=0xFF; Q holds at 0xFF; single TC_PULSE; BUSY falls; TC_COUNT=1.
- Periodic down, RELOAD=0x03 → Q sequence 03,02,01,00,03,02,...; TC_PULSE one cycle after each Q=00, i.e. every 4 cycles; TC_COUNT=3 after three periods.
- Free-run up, RELOAD=0xFE → Q FE,FF,00,01; TC_PULSE in the cycle after Q=FF; BUSY stays 1.
- One-shot up, RELOAD=0xFE, STOP asserted in the cycle Q=0xFF (tc) → no TC_PULSE, TC_COUNT=0, Q=0xFF, IDLE next cycle. START+STOP together in IDLE → stays IDLE.
- Bench chain model forces CNT_Q=0x00 after LOAD with RELOAD=0x55 → ERR=1 in cycle 3, BUSY=0. A new START runs normally with ERR still 1.
- Periodic up, RELOAD=0xFF, 300 cycles → TC_COUNT saturates at 255. CD pulsed mid-RUN between edges → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/lb_cnt_ctrl.sv
// lb_cnt_ctrl: control stage for a chain of cascaded 4-bit loadable up/down counter slices
module lb_cnt_ctrl #(
  parameter int NSLICE = 2,
  localparam int W = 4 * NSLICE
) (
  input  logic         CK,
  input  logic         CD,
  input  logic         START,
  input  logic         STOP,
  input  logic [1:0]   MODE,
  input  logic         DIR,
  input  logic [W-1:0] RELOAD,
  input  logic         CNT_CO,
  input  logic [W-1:0] CNT_Q,
  output logic         CNT_SP,
  output logic         CNT_SD,
  output logic         CNT_CON,
  output logic         CNT_CI,
  output logic [W-1:0] CNT_D,
  output logic         TC_PULSE,
  output logic         BUSY,
  output logic [7:0]   TC_COUNT,
  output logic         ERR
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_RUN} state_t;
  state_t       r_state;
  logic [1:0]   r_mode;
  logic         r_dir;
  logic [W-1:0] r_reload;
  logic         r_tc_pulse;
  logic [7:0]   r_tc_count;
  logic         r_err;
  logic         w_run;
  logic         w_tc;
  logic         w_oneshot;
  logic         w_periodic;
  // mode 11 is folded into one-shot at capture, so only 00/01/10 reach r_mode
  assign w_run      = r_state == S_RUN;
  assign w_tc       = w_run & (CNT_CO == r_dir);
  assign w_oneshot  = r_mode == 2'b00;
  assign w_periodic = r_mode == 2'b01;
  // one-shot tc freezes the chain on the terminal value; periodic tc swaps the wrap for a reload
  always_comb begin
    CNT_SP = (r_state == S_LOAD) | (w_run & ~STOP & ~(w_tc & w_oneshot));
    CNT_SD = (r_state == S_LOAD) | (w_run & ~STOP & w_tc & w_periodic);
  end
  assign CNT_CON  = r_dir;
  assign CNT_CI   = r_dir;
  assign CNT_D    = r_reload;
  assign TC_PULSE = r_tc_pulse;
  assign BUSY     = r_state != S_IDLE;
  assign TC_COUNT = r_tc_count;
  assign ERR      = r_err;
  // sequencing IDLE -> LOAD -> VERIFY -> RUN, terminal-count bookkeeping and sticky readback error
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'b00;
      r_dir      <= 1'b0;
      r_reload   <= '0;
      r_tc_pulse <= 1'b0;
      r_tc_count <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_tc_pulse <= w_tc & ~STOP;
      case (r_state)
        S_IDLE: if (START & ~STOP) begin
          r_mode     <= (MODE == 2'b11) ? 2'b00 : MODE;
          r_dir      <= DIR;
          r_reload   <= RELOAD;
          r_tc_count <= 8'd0;
          r_state    <= S_LOAD;
        end
        S_LOAD: r_state <= S_VERIFY;
        S_VERIFY: if (CNT_Q != r_reload) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end else r_state <= S_RUN;
        S_RUN: if (STOP) r_state <= S_IDLE;
        else if (w_tc) begin
          if (r_tc_count != 8'hFF) r_tc_count <= r_tc_count + 8'd1;
          if (w_oneshot) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lb_cnt_ctrl.sv
// tb_lb_cnt_ctrl: scoreboard bench for lb_cnt_ctrl driving a behavioural 8-bit slice chain
module tb_lb_cnt_ctrl;
  logic       CK = 0;
  logic       CD = 1;
  logic       START = 0;
  logic       STOP = 0;
  logic [1:0] MODE = 0;
  logic       DIR = 0;
  logic [7:0] RELOAD = 0;
  logic       CNT_CO;
  logic [7:0] CNT_Q;
  logic       CNT_SP, CNT_SD, CNT_CON, CNT_CI, TC_PULSE, BUSY, ERR;
  logic [7:0] CNT_D, TC_COUNT;

  lb_cnt_ctrl #(.NSLICE(2)) dut (
    .CK(CK), .CD(CD), .START(START), .STOP(STOP), .MODE(MODE), .DIR(DIR),
    .RELOAD(RELOAD), .CNT_CO(CNT_CO), .CNT_Q(CNT_Q), .CNT_SP(CNT_SP),
    .CNT_SD(CNT_SD), .CNT_CON(CNT_CON), .CNT_CI(CNT_CI), .CNT_D(CNT_D),
    .TC_PULSE(TC_PULSE), .BUSY(BUSY), .TC_COUNT(TC_COUNT), .ERR(ERR)
  );

  always #5 CK = ~CK;

  // counter chain: corrupt forces a bad parallel load to provoke a readback error
  logic [7:0] q = 8'h00;
  logic       corrupt = 0;
  always @(posedge CK)
    if (CNT_SP)
      q <= CNT_SD ? (corrupt ? 8'h00 : CNT_D) :
           (CNT_CON && CNT_CI) ? q + 8'd1 :
           (!CNT_CON && !CNT_CI) ? q - 8'd1 : q;
  assign CNT_Q  = q;
  assign CNT_CO = CNT_CON ? &q : |q;

  typedef struct {
    bit         end_ev;
    logic [7:0] q;
    logic [7:0] cnt;
    logic       err;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit e, input logic [7:0] qv, input logic [7:0] cv, input logic ev);
    exp_t x;
    x.end_ev = e; x.q = qv; x.cnt = cv; x.err = ev;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input bit e);
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got event kind %0d expected none", e);
    end else begin
      x = sb.pop_front();
      chk("ev_kind", 32'(e), 32'(x.end_ev));
      chk("ev_q", 32'(CNT_Q), 32'(x.q));
      chk("ev_tc_count", 32'(TC_COUNT), 32'(x.cnt));
      chk("ev_err", 32'(ERR), 32'(x.err));
    end
  endtask

  // monitor: a TC_PULSE or a BUSY falling edge is a DUT response that must match the scoreboard
  bit prev_busy = 0;
  initial forever begin
    @(negedge CK);
    if (!CD) begin
      if (TC_PULSE) pop_cmp(1'b0);
      if (prev_busy && !BUSY) pop_cmp(1'b1);
    end
    prev_busy = BUSY;
  end

  task automatic wait_neg();
    @(negedge CK);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic d, input logic [7:0] r);
    MODE = m; DIR = d; RELOAD = r; START = 1;
    wait_neg();
    START = 0; RELOAD = 8'h00; MODE = 2'b10; DIR = ~d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 400) begin wait_neg(); n++; end
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    chk("reset_outputs", {CNT_SP, CNT_SD, CNT_CON, CNT_CI, CNT_D, TC_PULSE, BUSY, TC_COUNT, ERR}, 0);
    wait_neg();
    wait_neg();
    CD = 0;
    wait_neg();

    // one-shot up from 0xFA: counts FA..FF, holds FF, one pulse
    push(0, 8'hFF, 8'd1, 0);
    push(1, 8'hFF, 8'd1, 0);
    start(2'b00, 1, 8'hFA);
    wait_idle();
    wait_neg();
    chk("t1_hold_q", 32'(CNT_Q), 32'hFF);
    chk("t1_tc_count", 32'(TC_COUNT), 32'd1);
    chk("t1_no_pulse", 32'(TC_PULSE), 32'd0);

    // periodic down from 0x03: pulse after every Q=00, reload to 03
    push(0, 8'h03, 8'd1, 0);
    push(0, 8'h03, 8'd2, 0);
    push(0, 8'h03, 8'd3, 0);
    push(1, 8'h03, 8'd3, 0);
    start(2'b01, 0, 8'h03);
    n = 0;
    while (TC_COUNT != 8'd3 && n < 100) begin wait_neg(); n++; end
    STOP = 1;
    wait_neg();
    STOP = 0;
    wait_idle();

    // free-run up from 0xFE: wraps to 00, pulse while still busy
    push(0, 8'h00, 8'd1, 0);
    push(1, 8'h00, 8'd1, 0);
    start(2'b10, 1, 8'hFE);
    n = 0;
    while (!TC_PULSE && n < 100) begin wait_neg(); n++; end
    chk("t3_busy", 32'(BUSY), 32'd1);
    STOP = 1;
    wait_neg();
    STOP = 0;
    wait_idle();

    // one-shot up from 0xFE, STOP in the tc cycle beats tc
    push(1, 8'hFF, 8'd0, 0);
    start(2'b11, 1, 8'hFE);
    n = 0;
    while (CNT_Q != 8'hFF && n < 100) begin wait_neg(); n++; end
    STOP = 1;
    wait_neg();
    STOP = 0;
    chk("t4_idle", 32'(BUSY), 32'd0);
    wait_neg();
    chk("t4_no_pulse", 32'(TC_PULSE), 32'd0);
    chk("t4_tc_count", 32'(TC_COUNT), 32'd0);
    START = 1; STOP = 1; MODE = 2'b00; DIR = 1; RELOAD = 8'h10;
    wait_neg();
    START = 0; STOP = 0;
    chk("t4_start_stop_idle", 32'(BUSY), 32'd0);
    wait_neg();
    chk("t4_start_stop_sp", 32'(CNT_SP), 32'd0);

    // readback error: bad load sets ERR and returns to IDLE in cycle 3
    push(1, 8'h00, 8'd0, 1);
    corrupt = 1;
    start(2'b00, 1, 8'h55);
    wait_neg();
    corrupt = 0;
    wait_neg();
    chk("t5_err", 32'(ERR), 32'd1);
    chk("t5_busy", 32'(BUSY), 32'd0);
    push(0, 8'hFF, 8'd1, 1);
    push(1, 8'hFF, 8'd1, 1);
    start(2'b00, 1, 8'hFE);
    wait_idle();

    // periodic up at 0xFF: tc every RUN cycle, TC_COUNT saturates
    for (int i = 1; i <= 300; i++) push(0, 8'hFF, (i > 255) ? 8'd255 : 8'(i), 1);
    start(2'b01, 1, 8'hFF);
    n = 0;
    while (sb.size() != 0 && n < 400) begin wait_neg(); n++; end
    chk("t6_saturate", 32'(TC_COUNT), 32'd255);
    chk("t6_busy", 32'(BUSY), 32'd1);
    #1;
    CD = 1;
    #1;
    chk("t6_async_reset", {CNT_SP, CNT_SD, CNT_CON, CNT_CI, CNT_D, TC_PULSE, BUSY, TC_COUNT, ERR}, 0);
    wait_neg();
    CD = 0;
    wait_neg();
    chk("t6_idle_after_reset", 32'(BUSY), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
